// File: rtl/master_bridge_async_fifo_wr_ctrl.sv
// Write-side controller of the master-bridge async FIFO: write pointer, full, almost-full, fill level.
// Optional sticky push-while-full flag o_overflow is enabled by defining MASTER_BRIDGE_FIFO_OVF_ERR_EN.
module master_bridge_async_fifo_wr_ctrl #(
    parameter int ADDR_WIDTH   = 3,
    parameter int AFULL_THRESH = 6
) (
    input  logic                  CLK,
    input  logic                  i_w_rst,
    input  logic                  i_push,
    input  logic [ADDR_WIDTH:0]   i_rd_gray_ptr_sync,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [ADDR_WIDTH:0]   o_wr_gray_ptr,
    output logic                  o_full,
    output logic                  o_almost_full,
    output logic [ADDR_WIDTH:0]   o_fill_level
`ifdef MASTER_BRIDGE_FIFO_OVF_ERR_EN
    ,
    output logic                  o_overflow
`endif
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] AFULL_LVL = (ADDR_WIDTH+1)'(AFULL_THRESH);

    function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
        logic [ADDR_WIDTH:0] b;
        b[ADDR_WIDTH] = g[ADDR_WIDTH];
        for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [ADDR_WIDTH:0] wr_bin_q,  wr_bin_d;
    logic [ADDR_WIDTH:0] wr_gray_q, wr_gray_d;
    logic [ADDR_WIDTH:0] fill_q,    fill_d;
    logic                full_q,    full_d;
    logic                afull_q,   afull_d;
    logic                accepted;
    logic [ADDR_WIDTH:0] rd_bin;
    logic [ADDR_WIDTH:0] rd_full_gray;

    always_comb begin
        accepted     = i_push & ~full_q;
        wr_bin_d     = accepted ? (wr_bin_q + PTR_ONE) : wr_bin_q;
        wr_gray_d    = wr_bin_d ^ (wr_bin_d >> 1);
        rd_bin       = gray2bin(i_rd_gray_ptr_sync);
        // Writer is one full lap ahead when the top two Gray bits differ and the rest match.
        // ADDR_WIDTH >= 2 is assumed for this slice.
        rd_full_gray = {~i_rd_gray_ptr_sync[ADDR_WIDTH:ADDR_WIDTH-1],
                        i_rd_gray_ptr_sync[ADDR_WIDTH-2:0]};
        full_d       = (wr_gray_d == rd_full_gray);
        fill_d       = wr_bin_d - rd_bin;
        afull_d      = (fill_d >= AFULL_LVL);
    end

    always_ff @(posedge CLK) begin
        if (i_w_rst) begin
            wr_bin_q  <= '0;
            wr_gray_q <= '0;
            fill_q    <= '0;
            full_q    <= 1'b0;
            afull_q   <= 1'b0;
        end else begin
            wr_bin_q  <= wr_bin_d;
            wr_gray_q <= wr_gray_d;
            fill_q    <= fill_d;
            full_q    <= full_d;
            afull_q   <= afull_d;
        end
    end

    assign o_wr_addr     = wr_bin_q[ADDR_WIDTH-1:0];
    assign o_wr_gray_ptr = wr_gray_q;
    assign o_full        = full_q;
    assign o_almost_full = afull_q;
    assign o_fill_level  = fill_q;

`ifdef MASTER_BRIDGE_FIFO_OVF_ERR_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q | (i_push & full_q);
    end

    always_ff @(posedge CLK) begin
        if (i_w_rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign o_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_master_bridge_async_fifo_wr_ctrl.sv
// Directed bench for master_bridge_async_fifo_wr_ctrl (ADDR_WIDTH=3, AFULL_THRESH=6).
// Expected values come from hand-computed constants and an occupancy model (wr - rd counts).
module tb_master_bridge_async_fifo_wr_ctrl;

    logic       CLK = 1'b0;
    logic       i_w_rst;
    logic       i_push;
    logic [3:0] i_rd_gray_ptr_sync;
    logic [2:0] o_wr_addr;
    logic [3:0] o_wr_gray_ptr;
    logic       o_full;
    logic       o_almost_full;
    logic [3:0] o_fill_level;
`ifdef MASTER_BRIDGE_FIFO_OVF_ERR_EN
    logic       o_overflow;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    master_bridge_async_fifo_wr_ctrl #(.ADDR_WIDTH(3), .AFULL_THRESH(6)) dut (
        .CLK                (CLK),
        .i_w_rst            (i_w_rst),
        .i_push             (i_push),
        .i_rd_gray_ptr_sync (i_rd_gray_ptr_sync),
        .o_wr_addr          (o_wr_addr),
        .o_wr_gray_ptr      (o_wr_gray_ptr),
        .o_full             (o_full),
        .o_almost_full      (o_almost_full),
        .o_fill_level       (o_fill_level)
`ifdef MASTER_BRIDGE_FIFO_OVF_ERR_EN
        ,
        .o_overflow         (o_overflow)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] to_gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    // Drive inputs, take one edge, settle away from the edge.
    task automatic cyc(input logic rst, input logic push, input logic [3:0] rd_bin);
        i_w_rst            = rst;
        i_push             = push;
        i_rd_gray_ptr_sync = to_gray(rd_bin);
        @(posedge CLK);
        #1;
    endtask

    // Expected outputs derived from model pointers via occupancy arithmetic.
    task automatic chk_state(input string tag, input logic [3:0] wr_m, input logic [3:0] rd_m);
        logic [3:0] occ;
        occ = wr_m - rd_m;
        chk({tag, "_addr"},  32'(o_wr_addr),     32'(wr_m[2:0]));
        chk({tag, "_gray"},  32'(o_wr_gray_ptr), 32'(to_gray(wr_m)));
        chk({tag, "_fill"},  32'(o_fill_level),  32'(occ));
        chk({tag, "_full"},  32'(o_full),        32'(occ == 4'd8));
        chk({tag, "_afull"}, 32'(o_almost_full), 32'(occ >= 4'd6));
    endtask

    logic [3:0] wr_m;
    logic [3:0] rd_m;

    initial begin
        i_w_rst = 1'b1;
        i_push  = 1'b1;
        i_rd_gray_ptr_sync = 4'b0101;

        // Reset with push asserted and a nonzero read pointer: everything must stay 0.
        for (int k = 0; k < 2; k++) begin
            @(posedge CLK);
            #1;
            chk_state("rst", 4'd0, 4'd0);
`ifdef MASTER_BRIDGE_FIFO_OVF_ERR_EN
            chk("rst_ovf", 32'(o_overflow), 32'd0);
`endif
        end
        wr_m = 4'd0;
        rd_m = 4'd0;

        // Fill: 8 back-to-back pushes, read pointer held at 0.
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b0, 1'b1, 4'd0);
            wr_m = 4'(k);
            chk_state($sformatf("fill%0d", k), wr_m, rd_m);
        end
        chk("fill_gray_1100", 32'(o_wr_gray_ptr), 32'b1100);
        chk("fill_full_hand", 32'(o_full), 32'd1);
        chk("fill_lvl_hand", 32'(o_fill_level), 32'd8);

        // Overflow: 3 pushes against a full FIFO are dropped.
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b1, 4'd0);
            chk_state($sformatf("ovf%0d", k), 4'd8, 4'd0);
`ifdef MASTER_BRIDGE_FIFO_OVF_ERR_EN
            chk("ovf_flag", 32'(o_overflow), 32'd1);
`endif
        end

        // Release: read pointer advances to 1.
        cyc(1'b0, 1'b0, 4'd1);
        rd_m = 4'd1;
        chk("rel_full", 32'(o_full), 32'd0);
        chk("rel_fill7", 32'(o_fill_level), 32'd7);
        chk_state("rel", wr_m, rd_m);
        cyc(1'b0, 1'b1, 4'd1);
        wr_m = 4'd9;
        chk("refill_full", 32'(o_full), 32'd1);
        chk_state("refill", wr_m, rd_m);
`ifdef MASTER_BRIDGE_FIFO_OVF_ERR_EN
        chk("ovf_sticky", 32'(o_overflow), 32'd1);
`endif

        // Simultaneous: reach fill 4, then push while the read pointer advances.
        cyc(1'b0, 1'b0, 4'd5);
        rd_m = 4'd5;
        chk("sim_pre_fill4", 32'(o_fill_level), 32'd4);
        cyc(1'b0, 1'b1, 4'd6);
        wr_m = 4'd10;
        rd_m = 4'd6;
        chk("sim_fill4", 32'(o_fill_level), 32'd4);
        chk("sim_afull0", 32'(o_almost_full), 32'd0);
        chk_state("sim", wr_m, rd_m);

        // Wrap: 40 accepted pushes with reads keeping occupancy at or below 3.
        begin
            int pushes = 0;
            int wraps  = 0;
            int cycles = 0;
            logic       p;
            logic [3:0] rd_n;
            logic [3:0] prev_wr;
            while (pushes < 40 && cycles < 400) begin
                p    = ((wr_m - rd_m) < 4'd3);
                rd_n = rd_m;
                if ((wr_m != rd_m) && (!p || cycles[0]))
                    rd_n = rd_m + 4'd1;
                cyc(1'b0, p, rd_n);
                prev_wr = wr_m;
                if (p) begin
                    wr_m = wr_m + 4'd1;
                    pushes++;
                end
                rd_m = rd_n;
                chk_state("wrap", wr_m, rd_m);
                if (prev_wr == 4'd15 && wr_m == 4'd0) begin
                    wraps++;
                    chk("wrap_gray0", 32'(o_wr_gray_ptr), 32'd0);
                end
                cycles++;
            end
            chk("wrap_budget", 32'(pushes), 32'd40);
            chk("wrap_count", 32'(wraps), 32'd3);
        end

        // Reset mid-operation clears everything in one cycle.
        cyc(1'b1, 1'b1, 4'd3);
        chk_state("rst_mid", 4'd0, 4'd0);
`ifdef MASTER_BRIDGE_FIFO_OVF_ERR_EN
        chk("rst_mid_ovf", 32'(o_overflow), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
